// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared constants and helpers for the UART receive path.
//   DATA_W       : byte width carried between uart_rx and its controller
//   DEF_BAUD_DIV : default clk cycles per baud tick
//   clamp_div()  : turns a programmed divisor into an effective one (>= 2)
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int DATA_W       = 8;
    localparam int DEF_BAUD_DIV = 10;

    // A divisor of 0 or 1 cannot produce a tick that is followed by a low
    // cycle, so both are raised to the shortest usable period of 2.
    function automatic logic [31:0] clamp_div(input logic [31:0] div);
        return (div < 32'd2) ? 32'd2 : div;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// -----------------------------------------------------------------------------
// uart_baud_gen
// Free-running divisor counter producing a one-cycle baud tick.
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   en   : run enable; when low the counter is held at 0 and no tick is made
//   div  : clk cycles per tick (0 and 1 behave as 2)
//   tick : one-cycle pulse when the counter reaches the last count
// -----------------------------------------------------------------------------
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] w_last;

    assign w_last = DIV_W'(clamp_div(32'(div)) - 32'd1);

    // '>=' rather than '==' so that shrinking the divisor below the current
    // count still ends the period at once instead of running the counter
    // all the way around.
    assign tick = en && (r_cnt >= w_last);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // values from before the edge, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (!en || tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// -----------------------------------------------------------------------------
// uart_rx_ctrl
// Sequences the uart_rx datapath: generates its baud tick, captures each
// completed byte on the rising edge of rx_ready into a small show-ahead FIFO,
// and hands bytes to the consumer over valid/ready with sticky overrun.
//   clk, rst       : system clock, asynchronous active-high reset
//   cfg_en         : enables baud ticks and byte capture
//   cfg_div        : clk cycles per baud tick (0/1 treated as 2)
//   baud_tick      : one-cycle pulse to uart_rx
//   rx_ready       : byte complete from uart_rx (may be held several cycles)
//   rx_data        : received byte, valid while rx_ready is high
//   m_valid/m_data : head of FIFO, show-ahead
//   m_ready        : consumer accepts the head byte
//   overrun        : sticky, a byte was dropped because the FIFO was full
//   clear_overrun  : clears overrun (a simultaneous drop wins)
//   level          : current FIFO occupancy
// -----------------------------------------------------------------------------
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DIV_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_en,
    input  logic [DIV_W-1:0]         cfg_div,
    output logic                     baud_tick,
    input  logic                     rx_ready,
    input  logic [DATA_W-1:0]        rx_data,
    output logic                     m_valid,
    output logic [DATA_W-1:0]        m_data,
    input  logic                     m_ready,
    output logic                     overrun,
    input  logic                     clear_overrun,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [LW-1:0]     r_level;
    logic [LW-1:0]     w_level_nxt;
    logic              r_rx_ready_q;
    logic              r_overrun;

    logic w_push;
    logic w_pop;
    logic w_full;
    logic w_accept;
    logic w_drop;

    uart_baud_gen #(
        .DIV_W (DIV_W)
    ) u_baud_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (cfg_en),
        .div  (cfg_div),
        .tick (baud_tick)
    );

    // One push per rx_ready high period, however long uart_rx holds it.
    assign w_push   = cfg_en && rx_ready && !r_rx_ready_q;
    assign m_valid  = (r_level != '0);
    assign w_pop    = m_valid && m_ready;
    assign w_full   = (r_level == LW'(DEPTH));
    // When full, a same-cycle pop frees the slot the write pointer sits on.
    assign w_accept = w_push && (!w_full || w_pop);
    assign w_drop   = w_push && w_full && !w_pop;

    // Gated so the output reads 0 when empty, including straight after reset.
    assign m_data   = m_valid ? r_mem[r_rd_ptr] : '0;
    assign level    = r_level;
    assign overrun  = r_overrun;

    // NOTE: every combinational output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w_level_nxt = r_level;
        if (w_accept && !w_pop) begin
            w_level_nxt = r_level + LW'(1);
        end else if (!w_accept && w_pop) begin
            w_level_nxt = r_level - LW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_level      <= '0;
            r_rx_ready_q <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_rx_ready_q <= rx_ready;
            r_level      <= w_level_nxt;
            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (clear_overrun) begin
                r_overrun <= 1'b0;
            end
        end
    end

    // NOTE: the storage array has no reset; entries are only visible once
    // written, because level and the read gating define what is valid.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[r_wr_ptr] <= rx_data;
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_ctrl
// Self-checking bench for uart_rx_ctrl. A queue-based model tracks the byte
// stream and the overrun flag; each scenario task compares DUT outputs with
// the model and with directly stated expectations.
// -----------------------------------------------------------------------------
module tb_uart_rx_ctrl;

    localparam int DEPTH = 4;
    localparam int DIV_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             cfg_en;
    logic [DIV_W-1:0] cfg_div;
    logic             baud_tick;
    logic             rx_ready;
    logic [7:0]       rx_data;
    logic             m_valid;
    logic [7:0]       m_data;
    logic             m_ready;
    logic             overrun;
    logic             clear_overrun;
    logic [2:0]       level;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model state
    logic [7:0] mq[$];
    bit         m_ovr;
    bit         m_prev_ready;

    uart_rx_ctrl #(
        .DEPTH (DEPTH),
        .DIV_W (DIV_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_en        (cfg_en),
        .cfg_div       (cfg_div),
        .baud_tick     (baud_tick),
        .rx_ready      (rx_ready),
        .rx_data       (rx_data),
        .m_valid       (m_valid),
        .m_data        (m_data),
        .m_ready       (m_ready),
        .overrun       (overrun),
        .clear_overrun (clear_overrun),
        .level         (level)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] exp_data();
        return (mq.size() != 0) ? mq[0] : 8'h00;
    endfunction

    function automatic logic [2:0] exp_level();
        return 3'(mq.size());
    endfunction

    // Advance one clock with the inputs currently driven, updating the model
    // from the block's rules; returns at the following negedge.
    task automatic clk_cycle();
        int         sz;
        bit         push;
        bit         pop;
        logic [7:0] d;
        sz   = mq.size();
        pop  = (sz != 0) && (m_ready === 1'b1);
        push = (cfg_en === 1'b1) && (rx_ready === 1'b1) && !m_prev_ready;
        d    = rx_data;
        @(posedge clk);
        m_prev_ready = (rx_ready === 1'b1);
        if (pop) void'(mq.pop_front());
        if (push && (sz < DEPTH || pop)) mq.push_back(d);
        if (push && sz == DEPTH && !pop) m_ovr = 1'b1;
        else if (clear_overrun === 1'b1) m_ovr = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_ready = 1'b1;
        clk_cycle();
        rx_ready = 1'b0;
        clk_cycle();
    endtask

    task automatic drain();
        m_ready = 1'b1;
        for (int k = 0; k < 2 * DEPTH && mq.size() != 0; k++) clk_cycle();
        m_ready = 1'b0;
        n_total++;
        if (m_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL drain_empty: m_valid=%b required 0", m_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; cfg_en = 1'b0; cfg_div = 16'(uart_pkg::DEF_BAUD_DIV);
        rx_ready = 1'b0; rx_data = 8'h00; m_ready = 1'b0; clear_overrun = 1'b0;
        mq.delete(); m_ovr = 1'b0; m_prev_ready = 1'b0;
        repeat (3) @(negedge clk);
        n_total += 5;
        if (m_valid !== 1'b0)   begin n_bad++; $display("FAIL reset_m_valid: got %b want 0", m_valid); end
        if (m_data !== 8'h00)   begin n_bad++; $display("FAIL reset_m_data: got %h want 00", m_data); end
        if (level !== 3'd0)     begin n_bad++; $display("FAIL reset_level: got %0d want 0", level); end
        if (overrun !== 1'b0)   begin n_bad++; $display("FAIL reset_overrun: got %b want 0", overrun); end
        if (baud_tick !== 1'b0) begin n_bad++; $display("FAIL reset_tick: got %b want 0", baud_tick); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Enables the generator from a zeroed counter and compares baud_tick each
    // cycle with a tick expected every max(div,2) cycles, on the last count.
    task automatic run_baud(input logic [DIV_W-1:0] div, input int n, input bit en);
        int period;
        period = (div < 2) ? 2 : int'(div);
        cfg_en = 1'b0;
        clk_cycle();
        cfg_div = div;
        cfg_en  = en;
        for (int i = 0; i < n; i++) begin
            logic want;
            want = en && ((i % period) == period - 1);
            n_total++;
            if (baud_tick !== want) begin
                n_bad++;
                $display("FAIL baud div=%0d en=%0b cyc=%0d: got %b want %b", div, en, i, baud_tick, want);
            end
            clk_cycle();
        end
    endtask

    task automatic test_baud();
        run_baud(16'd10, 35, 1'b1);
        run_baud(16'd0, 8, 1'b1);
        run_baud(16'd1, 8, 1'b1);
        run_baud(16'd3, 10, 1'b1);
        run_baud(16'd10, 25, 1'b0);
        cfg_en  = 1'b1;
        cfg_div = 16'(uart_pkg::DEF_BAUD_DIV);
    endtask

    task automatic test_capture_single();
        rx_data  = 8'hA5;
        rx_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            clk_cycle();
            n_total += 3;
            if (m_valid !== 1'b1) begin n_bad++; $display("FAIL cap_valid c=%0d: got %b want 1", c, m_valid); end
            if (m_data !== 8'hA5) begin n_bad++; $display("FAIL cap_data c=%0d: got %h want a5", c, m_data); end
            if (level !== 3'd1)   begin n_bad++; $display("FAIL cap_level c=%0d: got %0d want 1", c, level); end
            rx_data = 8'h5A;  // must not be captured while rx_ready stays high
        end
        rx_ready = 1'b0;
        clk_cycle();
        drain();
    endtask

    task automatic test_order();
        logic [7:0] seq [3];
        seq[0] = 8'h00; seq[1] = 8'hFF; seq[2] = 8'h3C;
        for (int k = 0; k < 3; k++) send_byte(seq[k]);
        n_total++;
        if (level !== 3'd3) begin n_bad++; $display("FAIL order_level: got %0d want 3", level); end
        m_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            n_total += 2;
            if (m_valid !== 1'b1) begin n_bad++; $display("FAIL order_valid k=%0d: got %b want 1", k, m_valid); end
            if (m_data !== seq[k]) begin n_bad++; $display("FAIL order_data k=%0d: got %h want %h", k, m_data, seq[k]); end
            clk_cycle();
        end
        m_ready = 1'b0;
        n_total++;
        if (m_valid !== 1'b0) begin n_bad++; $display("FAIL order_empty: got %b want 0", m_valid); end
    endtask

    // Fills past DEPTH, then checks set-beats-clear and a full push+pop.
    task automatic test_overrun_and_full();
        logic [7:0] tail [4];
        for (int k = 1; k <= 5; k++) send_byte(8'(k));
        n_total += 3;
        if (level !== 3'd4)   begin n_bad++; $display("FAIL ovr_level: got %0d want 4", level); end
        if (overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_flag: got %b want 1", overrun); end
        if (m_data !== 8'h01) begin n_bad++; $display("FAIL ovr_head: got %h want 01", m_data); end

        rx_data = 8'h66; rx_ready = 1'b1; clear_overrun = 1'b1;
        clk_cycle();
        rx_ready = 1'b0; clear_overrun = 1'b0;
        n_total += 2;
        if (overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_set_wins: got %b want 1", overrun); end
        if (level !== 3'd4)   begin n_bad++; $display("FAIL ovr_set_level: got %0d want 4", level); end
        clk_cycle();
        clear_overrun = 1'b1;
        clk_cycle();
        clear_overrun = 1'b0;
        n_total++;
        if (overrun !== 1'b0) begin n_bad++; $display("FAIL ovr_clear: got %b want 0", overrun); end

        rx_data = 8'h77; rx_ready = 1'b1; m_ready = 1'b1;
        clk_cycle();
        rx_ready = 1'b0; m_ready = 1'b0;
        n_total += 3;
        if (level !== 3'd4)   begin n_bad++; $display("FAIL full_pp_level: got %0d want 4", level); end
        if (overrun !== 1'b0) begin n_bad++; $display("FAIL full_pp_ovr: got %b want 0", overrun); end
        if (m_data !== 8'h02) begin n_bad++; $display("FAIL full_pp_head: got %h want 02", m_data); end
        tail[0] = 8'h02; tail[1] = 8'h03; tail[2] = 8'h04; tail[3] = 8'h77;
        m_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n_total++;
            if (m_data !== tail[k]) begin n_bad++; $display("FAIL full_pp_order k=%0d: got %h want %h", k, m_data, tail[k]); end
            clk_cycle();
        end
        m_ready = 1'b0;
        n_total++;
        if (m_valid !== 1'b0) begin n_bad++; $display("FAIL full_pp_empty: got %b want 0", m_valid); end
    endtask

    task automatic test_async_reset();
        for (int k = 0; k < 5; k++) send_byte(8'($urandom_range(255)));
        m_ready = 1'b1;
        clk_cycle();
        m_ready = 1'b0;
        n_total += 2;
        if (level !== 3'd3)   begin n_bad++; $display("FAIL ar_pre_level: got %0d want 3", level); end
        if (overrun !== 1'b1) begin n_bad++; $display("FAIL ar_pre_ovr: got %b want 1", overrun); end
        #2 rst = 1'b1;
        #1;
        n_total += 4;
        if (m_valid !== 1'b0) begin n_bad++; $display("FAIL ar_valid: got %b want 0", m_valid); end
        if (level !== 3'd0)   begin n_bad++; $display("FAIL ar_level: got %0d want 0", level); end
        if (overrun !== 1'b0) begin n_bad++; $display("FAIL ar_ovr: got %b want 0", overrun); end
        if (m_data !== 8'h00) begin n_bad++; $display("FAIL ar_data: got %h want 00", m_data); end
        mq.delete(); m_ovr = 1'b0; m_prev_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        send_byte(8'hC3);
        n_total += 3;
        if (m_valid !== 1'b1) begin n_bad++; $display("FAIL ar_after_valid: got %b want 1", m_valid); end
        if (m_data !== 8'hC3) begin n_bad++; $display("FAIL ar_after_data: got %h want c3", m_data); end
        if (level !== 3'd1)   begin n_bad++; $display("FAIL ar_after_level: got %0d want 1", level); end
        drain();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(2) == 0) rx_ready = ~rx_ready;
            rx_data       = 8'($urandom_range(255));
            m_ready       = ($urandom_range(2) == 0);
            clear_overrun = ($urandom_range(9) == 0);
            cfg_en        = ($urandom_range(7) != 0);
            clk_cycle();
            n_total += 4;
            if (m_valid !== (mq.size() != 0)) begin n_bad++; $display("FAIL rnd_valid i=%0d: got %b want %b", i, m_valid, mq.size() != 0); end
            if (m_data !== exp_data())        begin n_bad++; $display("FAIL rnd_data i=%0d: got %h want %h", i, m_data, exp_data()); end
            if (level !== exp_level())        begin n_bad++; $display("FAIL rnd_level i=%0d: got %0d want %0d", i, level, exp_level()); end
            if (overrun !== m_ovr)            begin n_bad++; $display("FAIL rnd_ovr i=%0d: got %b want %b", i, overrun, m_ovr); end
        end
        rx_ready = 1'b0; m_ready = 1'b0; clear_overrun = 1'b0; cfg_en = 1'b1;
        clk_cycle();
    endtask

    initial begin
        test_reset();
        test_baud();
        test_capture_single();
        test_order();
        test_overrun_and_full();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Controller that sequences the uart_rx datapath. It generates uart_rx's baud_tick from a programmable divisor. It captures each completed byte on the rising edge of rx_ready and buffers the bytes in a small FIFO. It presents them to the consumer over a valid/ready handshake, with sticky overrun reporting. It sits between uart_rx and the host-side byte consumer.

Parameters:
DEPTH, 4, FIFO entries; power of two, at least 2
DIV_W, 16, width of the baud divisor
DATA_W, 8, byte width (from uart_pkg)

Ports:
clk  in  1  system clock; the block's only clock
rst  in  1  reset, asynchronous, active-high
cfg_en  in  1  enables the baud generator and byte capture
cfg_div  in  DIV_W  clk cycles per baud tick; values 0 and 1 are treated as 2
baud_tick  out  1  one-cycle pulse driven to uart_rx.baud_tick
rx_ready  in  1  from uart_rx; may stay high for several cycles
rx_data  in  DATA_W  from uart_rx.shift_reg; valid while rx_ready is high
m_valid  out  1  FIFO non-empty
m_data  out  DATA_W  head-of-FIFO byte (show-ahead)
m_ready  in  1  consumer accept
overrun  out  1  sticky: a byte was dropped
clear_overrun  in  1  clears overrun
level  out  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (async assert, synchronous-to-clk release):
  - baud_tick=0, m_valid=0, m_data=0, overrun=0, level=0.
  - Baud counter=0, FIFO pointers=0, rx_ready edge register=0.
- Baud generator:
  - Counter runs 0..D-1, where D=max(cfg_div,2).
  - baud_tick=1 for exactly one cycle when counter==D-1; counter then wraps to 0.
  - cfg_en=0: counter held at 0, baud_tick=0.
  - If cfg_div changes mid-count and counter>=D-1: next cycle ticks and wraps.
- Capture:
  - push = cfg_en & rx_ready & ~rx_ready_q, where rx_ready_q is rx_ready registered.
  - Exactly one push per rx_ready high period; rx_data is sampled in the push cycle.
  - Push in cycle N gives m_valid=1 and the new data (if the FIFO was empty) in cycle N+1.
- Pop:
  - pop = m_valid & m_ready. The head advances at the clock edge.
  - m_data and m_valid are stable while m_valid=1 and m_ready=0.
- Full/empty:
  - Push when level<DEPTH: write, level+1.
  - Push when level==DEPTH with pop in the same cycle: accepted, level unchanged.
  - Push when level==DEPTH without pop: byte dropped, FIFO unchanged, overrun=1 from the next cycle.
  - Pop when empty: impossible, since m_valid=0.
  - Push and pop with 0<level<DEPTH: level unchanged, data order preserved.
- Pointers: log2(DEPTH) bits, wrap naturally; level is computed separately.
- Overrun:
  - Set by a dropped push; cleared by clear_overrun.
  - Set and clear in the same cycle: set wins.
- cfg_en=0: FIFO contents, m_valid, overrun and pop all continue to operate; only ticks and captures stop.
- Reset mid-frame or with a non-empty FIFO: all contents discarded, outputs return to reset values immediately.

Decomposition:
- uart_pkg holds:
  - DATA_W=8
  - DEF_BAUD_DIV=10
  - a function clamping the divisor to at least 2
- Sub-module uart_baud_gen (clk, rst, en, div, tick) holds the divisor counter.
- FIFO storage and capture stay inline.

Test Plan:
1. cfg_en=1, cfg_div=10 -> baud_tick pulses every 10 clk cycles, each 1 cycle wide. cfg_div=0 -> period 2. cfg_en=0 -> no ticks.
2. rx_ready held high 3 cycles with rx_data=0xA5 -> exactly one push; m_valid and m_data=0xA5 the next cycle; level=1.
3. Bytes 0x00, 0xFF, 0x3C captured with m_ready=0, then m_ready=1 -> delivered in order 0x00, 0xFF, 0x3C; m_valid falls after the third pop.
4. DEPTH=4, m_ready=0, 5 bytes 0x01..0x05 -> level=4, overrun=1, head=0x01, 0x05 lost. clear_overrun and a new drop in the same cycle -> overrun stays 1.
5. FIFO full, push coincident with pop -> level stays 4, the pushed byte becomes the tail, overrun stays 0.
6. rst asserted asynchronously mid-stream with level=3 -> m_valid=0, level=0 and overrun=0 without waiting for a clk edge; normal operation after release.
